// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals shared between the two requesters,
// the arbiter and the external combinational ALU.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [2:0]        req_op0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;
    logic [2:0]        req_op1;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_err;

    logic              busy;
    logic [15:0]       op_cnt;

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        input  alu_out, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy, op_cnt
    );

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        output alu_out, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy, op_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with registered ALU inputs and a single tagged, backpressured response.
module alu_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last;
    logic        grant_id;
    logic [1:0]  grant;
    logic [2:0]  grant_op;
    logic        grant_illegal;
    logic        id_q;
    logic        err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        grant     = 2'b00;
        grant_id  = (bus.req_valid == 2'b11) ? ~last : bus.req_valid[1];
        case (state)
            IDLE: if (|bus.req_valid) begin
                grant     = grant_id ? 2'b10 : 2'b01;
                state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Codes 100 and 101 have no ALU function.
    assign grant_op      = grant_id ? bus.req_op1 : bus.req_op0;
    assign grant_illegal = (grant_op[2:1] == 2'b10);

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last         <= 1'b1;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_ctrl <= 3'b000;
            bus.rsp_id   <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_zero <= 1'b0;
            bus.rsp_err  <= 1'b0;
            bus.op_cnt   <= 16'd0;
        end else begin
            if (grant != 2'b00) begin
                last         <= grant_id;
                id_q         <= grant_id;
                err_q        <= grant_illegal;
                bus.alu_a    <= grant_id ? bus.req_a1 : bus.req_a0;
                bus.alu_b    <= grant_id ? bus.req_b1 : bus.req_b0;
                bus.alu_ctrl <= grant_illegal ? 3'b000 : grant_op;
            end
            // The ALU settles during EXEC; its result is captured on the closing edge.
            if (state == EXEC) begin
                bus.rsp_id   <= id_q;
                bus.rsp_err  <= err_q;
                bus.rsp_data <= err_q ? '0 : bus.alu_out;
                bus.rsp_zero <= err_q ? 1'b0 : bus.alu_zero;
            end
            if (state == RESP && bus.rsp_ready)
                bus.op_cnt <= bus.op_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: drives both requesters, models the ALU,
// and checks grants, responses, backpressure and reset against hand values.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic [15:0] exp_cnt;

    alu_arbiter_if #(.DATA_W(32)) bus ();

    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU sitting on the registered operands.
    logic [31:0] alu_diff;
    always_comb begin
        alu_diff = bus.alu_a - bus.alu_b;
        case (bus.alu_ctrl)
            3'b000:         bus.alu_out = bus.alu_a | bus.alu_b;
            3'b001:         bus.alu_out = bus.alu_a & bus.alu_b;
            3'b010:         bus.alu_out = bus.alu_a + bus.alu_b;
            3'b110:         bus.alu_out = alu_diff;
            3'b011, 3'b111: bus.alu_out = {31'd0, alu_diff[31]};
            default:        bus.alu_out = 32'd0;
        endcase
        bus.alu_zero = (bus.alu_a == bus.alu_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        check("rst_alu_a",     bus.alu_a, 32'd0);
        check("rst_alu_b",     bus.alu_b, 32'd0);
        check("rst_alu_ctrl",  {29'd0, bus.alu_ctrl}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_id",    {31'd0, bus.rsp_id}, 32'd0);
        check("rst_rsp_data",  bus.rsp_data, 32'd0);
        check("rst_rsp_flags", {30'd0, bus.rsp_zero, bus.rsp_err}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy}, 32'd0);
        check("rst_op_cnt",    {16'd0, bus.op_cnt}, 32'd0);
        exp_cnt = 16'd0;
        rst_n   = 1'b1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (id == 0) begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; bus.req_valid[0] = 1'b1;
        end else begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; bus.req_valid[1] = 1'b1;
        end
    endtask

    // Waits (bounded) for a grant in IDLE and checks which requester won.
    task automatic wait_grant(input string tag, input logic [1:0] exp);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) break;
        end
        check(tag, {30'd0, bus.req_ready}, {30'd0, exp});
    endtask

    task automatic check_exec(input string tag, input logic [2:0] exp_ctrl);
        @(negedge clk);
        check({tag, "_exec_busy"},  {31'd0, bus.busy}, 32'd1);
        check({tag, "_exec_ctrl"},  {29'd0, bus.alu_ctrl}, {29'd0, exp_ctrl});
        check({tag, "_exec_ready"}, {30'd0, bus.req_ready}, 32'd0);
    endtask

    task automatic check_resp(input string tag, input logic id, input logic [31:0] data,
                              input logic zero, input logic err);
        @(negedge clk);
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, "_rsp_id"},    {31'd0, bus.rsp_id}, {31'd0, id});
        check({tag, "_rsp_data"},  bus.rsp_data, data);
        check({tag, "_rsp_flags"}, {30'd0, bus.rsp_zero, bus.rsp_err}, {30'd0, zero, err});
    endtask

    // Handshake on the current negedge; returns #1 after the accepting edge.
    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        exp_cnt++;
        check({tag, "_op_cnt"},    {16'd0, bus.op_cnt}, {16'd0, exp_cnt});
        check({tag, "_rsp_drop"},  {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic do_txn(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [2:0] exp_ctrl, input logic [31:0] exp_data,
                          input logic exp_zero, input logic exp_err);
        @(posedge clk);
        #1;
        set_req(id, a, b, op);
        wait_grant({tag, "_grant"}, (id == 0) ? 2'b01 : 2'b10);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        check_exec(tag, exp_ctrl);
        check_resp(tag, id[0], exp_data, exp_zero, exp_err);
        finish_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 16'd0;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;
        apply_reset();

        // Single ADD from requester 0.
        do_txn("add0", 0, 32'd5, 32'd3, 3'b010, 3'b010, 32'd8, 1'b0, 1'b0);

        // Requester 1 alone: SUB, SLT, AND.
        do_txn("sub1", 1, 32'd5, 32'd3, 3'b110, 3'b110, 32'd2, 1'b0, 1'b0);
        do_txn("slt1", 1, 32'd3, 32'd5, 3'b111, 3'b111, 32'd1, 1'b0, 1'b0);
        do_txn("and1", 1, 32'h0000_F0F0, 32'h0000_FF00, 3'b001, 3'b001, 32'h0000_F000, 1'b0, 1'b0);

        // Both requesters held high from reset: grants alternate 0,1,0,1.
        apply_reset();
        @(posedge clk);
        #1;
        set_req(0, 32'd10, 32'd4, 3'b010);
        set_req(1, 32'd10, 32'd4, 3'b110);
        for (int k = 0; k < 4; k++) begin
            wait_grant("rr_grant", (k % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk);
            #1;
            if (k == 3) bus.req_valid = 2'b00;
            check_exec("rr", (k % 2 == 0) ? 3'b010 : 3'b110);
            check_resp("rr", (k % 2 == 1), (k % 2 == 0) ? 32'd14 : 32'd6, 1'b0, 1'b0);
            finish_rsp("rr");
        end

        // Illegal op: ALU sees OR of equal operands but the response is forced clean.
        do_txn("illegal", 0, 32'd7, 32'd7, 3'b100, 3'b000, 32'd0, 1'b0, 1'b1);

        // Backpressure with requester 1 waiting during RESP.
        @(posedge clk);
        #1;
        set_req(0, 32'd1, 32'd2, 3'b010);
        wait_grant("bp_grant0", 2'b01);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        check_exec("bp0", 3'b010);
        check_resp("bp0", 1'b0, 32'd3, 1'b0, 1'b0);
        set_req(1, 32'd9, 32'd9, 3'b110);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_hold_data",  bus.rsp_data, 32'd3);
            check("bp_hold_id",    {31'd0, bus.rsp_id}, 32'd0);
            check("bp_hold_ready", {30'd0, bus.req_ready}, 32'd0);
            check("bp_hold_busy",  {31'd0, bus.busy}, 32'd1);
        end
        finish_rsp("bp0");
        @(negedge clk);
        check("bp_grant1_first_idle", {30'd0, bus.req_ready}, 32'd2);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        check_exec("bp1", 3'b110);
        check_resp("bp1", 1'b1, 32'd0, 1'b1, 1'b0);
        finish_rsp("bp1");

        // Reset during EXEC discards the transaction.
        @(posedge clk);
        #1;
        set_req(0, 32'd1, 32'd1, 3'b010);
        wait_grant("xrst_grant", 2'b01);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("xrst_in_exec", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("xrst_busy",      {31'd0, bus.busy}, 32'd0);
        check("xrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("xrst_alu_a",     bus.alu_a, 32'd0);
        check("xrst_alu_ctrl",  {29'd0, bus.alu_ctrl}, 32'd0);
        check("xrst_op_cnt",    {16'd0, bus.op_cnt}, 32'd0);
        check("xrst_rsp_data",  bus.rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("xrst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            check("xrst_cnt",    {16'd0, bus.op_cnt}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
